// File: rtl/mosaico_pkg.sv
// Shared constants and the 8x16 font ROM for the text-tile renderer.
package mosaico_pkg;

    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned GLYPH_H = 16;

    localparam int unsigned BLANCO  = 0;
    localparam int unsigned LETRA_D = 1;
    localparam int unsigned LETRA_J = 2;

    typedef logic [GLYPH_W-1:0] fila_t;

    // One glyph row; MSB is the leftmost pixel. Codes other than D/J are blank.
    function automatic fila_t fuente_fila(input int unsigned code, input logic [3:0] row);
        fila_t f;
        f = '0;
        case (code)
            LETRA_D: begin
                case (row)
                    4'd0, 4'd15: f = '0;
                    4'd1, 4'd14: f = 8'hF8;
                    4'd2, 4'd13: f = 8'h6C;
                    default:     f = 8'h66;
                endcase
            end
            LETRA_J: begin
                case (row)
                    4'd0, 4'd15:        f = '0;
                    4'd1:               f = 8'h1E;
                    4'd11, 4'd12, 4'd13: f = 8'hCC;
                    4'd14:              f = 8'h78;
                    default:            f = 8'h0C;
                endcase
            end
            BLANCO:  f = '0;
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/texto_mosaico_param_if.sv
// Pixel/video and character-buffer write signals of the text-tile renderer.
interface texto_mosaico_param_if #(
    parameter int unsigned H_BITS    = 10,
    parameter int unsigned V_BITS    = 10,
    parameter int unsigned NUM_CHARS = 4,
    parameter int unsigned CODE_BITS = 2
);
    localparam int unsigned ADDR_BITS = $clog2(NUM_CHARS);

    logic [H_BITS-1:0]    Qh;
    logic [V_BITS-1:0]    Qv;
    logic                 video_on;
    logic                 escala;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [CODE_BITS-1:0] wr_code;
    logic                 bit_fuente;
    logic                 en_texto;

    modport master (
        output Qh, Qv, video_on, escala, wr_en, wr_addr, wr_code,
        input  bit_fuente, en_texto
    );

    modport slave (
        input  Qh, Qv, video_on, escala, wr_en, wr_addr, wr_code,
        output bit_fuente, en_texto
    );

endinterface

// File: rtl/texto_mosaico_param_buffer.sv
// Character-code register file: one synchronous write port, one registered read port.
module buffer_caracteres #(
    parameter int unsigned NUM_CHARS = 4,
    parameter int unsigned CODE_BITS = 2,
    localparam int unsigned ADDR_BITS = $clog2(NUM_CHARS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [CODE_BITS-1:0] wr_code_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    output logic [CODE_BITS-1:0] rd_code_o
);

    logic [CODE_BITS-1:0] mem_q [NUM_CHARS];
    logic [CODE_BITS-1:0] rd_code_q;

    // Storage and read register; reset beats a same-cycle write, and a read of the
    // slot being written returns the old code.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_CHARS; i++) begin
                mem_q[i] <= '0;
            end
            rd_code_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_addr_i] <= wr_code_i;
            end
            rd_code_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_code_o = rd_code_q;

endmodule

// File: rtl/texto_mosaico_param.sv
// Three-stage text-tile renderer: window compare, buffer read, font bit select.
module texto_mosaico_param
    import mosaico_pkg::*;
#(
    parameter int unsigned H_BITS    = 10,
    parameter int unsigned V_BITS    = 10,
    parameter int unsigned NUM_CHARS = 4,
    parameter int unsigned CODE_BITS = 2,
    parameter int unsigned ORIGIN_X  = 400,
    parameter int unsigned ORIGIN_Y  = 256
) (
    input logic                 reloj,
    input logic                 resetM,
    texto_mosaico_param_if.slave bus
);

    localparam int unsigned ADDR_BITS = $clog2(NUM_CHARS);
    localparam logic [H_BITS:0] ORG_X    = (H_BITS+1)'(ORIGIN_X);
    localparam logic [V_BITS:0] ORG_Y    = (V_BITS+1)'(ORIGIN_Y);
    localparam logic [H_BITS:0] ANCHO_1X = (H_BITS+1)'(NUM_CHARS * GLYPH_W);
    localparam logic [V_BITS:0] ALTO_1X  = (V_BITS+1)'(GLYPH_H);

    // Stage 1 combinational results
    logic [H_BITS-1:0]    rel_x;
    logic [V_BITS-1:0]    rel_y;
    logic [H_BITS:0]      lim_x;
    logic [V_BITS:0]      lim_y;
    logic                 win_d;
    logic [ADDR_BITS-1:0] idx_d;
    logic [2:0]           gcol_d;
    logic [3:0]           grow_d;

    // Stage 1 registers
    logic [ADDR_BITS-1:0] idx1_q;
    logic [2:0]           gcol1_q;
    logic [3:0]           grow1_q;
    logic                 win1_q;

    // Stage 2 registers (code comes from the buffer's read register)
    logic [CODE_BITS-1:0] code2;
    logic [2:0]           gcol2_q;
    logic [3:0]           grow2_q;
    logic                 win2_q;

    // Stage 3
    fila_t                fila;
    logic                 bit_d;
    logic                 bit_q;
    logic                 en_q;

    // Window test and tile/glyph coordinates; the >= compare masks subtraction wrap.
    always_comb begin
        rel_x  = bus.Qh - ORG_X[H_BITS-1:0];
        rel_y  = bus.Qv - ORG_Y[V_BITS-1:0];
        lim_x  = ANCHO_1X << bus.escala;
        lim_y  = ALTO_1X << bus.escala;
        win_d  = ({1'b0, bus.Qh} >= ORG_X) && ({1'b0, rel_x} < lim_x) &&
                 ({1'b0, bus.Qv} >= ORG_Y) && ({1'b0, rel_y} < lim_y) &&
                 bus.video_on;
        idx_d  = ADDR_BITS'(rel_x >> (bus.escala ? 4 : 3));
        gcol_d = 3'(rel_x >> bus.escala);
        grow_d = 4'(rel_y >> bus.escala);
    end

    // Stage 1 pipeline register
    always_ff @(posedge reloj) begin
        if (resetM) begin
            idx1_q  <= '0;
            gcol1_q <= '0;
            grow1_q <= '0;
            win1_q  <= 1'b0;
        end else begin
            idx1_q  <= idx_d;
            gcol1_q <= gcol_d;
            grow1_q <= grow_d;
            win1_q  <= win_d;
        end
    end

    buffer_caracteres #(
        .NUM_CHARS (NUM_CHARS),
        .CODE_BITS (CODE_BITS)
    ) u_buffer (
        .clk_i     (reloj),
        .rst_i     (resetM),
        .wr_en_i   (bus.wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_code_i (bus.wr_code),
        .rd_addr_i (idx1_q),
        .rd_code_o (code2)
    );

    // Stage 2 pipeline register, aligned with the buffer read
    always_ff @(posedge reloj) begin
        if (resetM) begin
            gcol2_q <= '0;
            grow2_q <= '0;
            win2_q  <= 1'b0;
        end else begin
            gcol2_q <= gcol1_q;
            grow2_q <= grow1_q;
            win2_q  <= win1_q;
        end
    end

    // Font lookup and pixel select, gated by the window flag
    always_comb begin
        fila  = fuente_fila(32'(code2), grow2_q);
        bit_d = fila[3'd7 - gcol2_q] & win2_q;
    end

    // Stage 3 output register
    always_ff @(posedge reloj) begin
        if (resetM) begin
            bit_q <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            bit_q <= bit_d;
            en_q  <= win2_q;
        end
    end

    assign bus.bit_fuente = bit_q;
    assign bus.en_texto   = en_q;

endmodule

// File: tb/tb_texto_mosaico_param.sv
// Directed self-checking bench for texto_mosaico_param.
module tb_texto_mosaico_param;

    logic reloj = 1'b0;
    logic resetM = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 reloj = ~reloj;

    texto_mosaico_param_if #(
        .H_BITS    (10),
        .V_BITS    (10),
        .NUM_CHARS (4),
        .CODE_BITS (2)
    ) bus ();

    texto_mosaico_param #(
        .H_BITS    (10),
        .V_BITS    (10),
        .NUM_CHARS (4),
        .CODE_BITS (2),
        .ORIGIN_X  (400),
        .ORIGIN_Y  (256)
    ) dut (
        .reloj  (reloj),
        .resetM (resetM),
        .bus    (bus)
    );

    // Drive one pixel and sample the outputs after the third rising edge.
    task automatic run_pixel(input logic [9:0] h, input logic [9:0] v, input logic vid,
                             input logic esc, output logic b, output logic e);
        @(negedge reloj);
        bus.Qh = h; bus.Qv = v; bus.video_on = vid; bus.escala = esc;
        repeat (3) @(posedge reloj);
        #1;
        b = bus.bit_fuente;
        e = bus.en_texto;
    endtask

    task automatic write_slot(input logic [1:0] a, input logic [1:0] c);
        @(negedge reloj);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_code = c;
        @(posedge reloj);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge reloj);
        resetM = 1'b1;
        bus.Qh = 10'd400; bus.Qv = 10'd257; bus.video_on = 1'b1; bus.escala = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge reloj); #1;
            n_checks++;
            if (bus.bit_fuente !== 1'b0 || bus.en_texto !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: bit=%b en=%b, expected 0/0", i, bus.bit_fuente, bus.en_texto);
            end
        end
        @(negedge reloj);
        resetM = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge reloj); #1;
            n_checks++;
            if (bus.bit_fuente !== 1'b0 || bus.en_texto !== (i == 3)) begin
                n_fail++;
                $display("FAIL reset_flush[%0d]: bit=%b en=%b, expected 0/%0d", i, bus.bit_fuente, bus.en_texto, (i == 3));
            end
        end
        begin
            logic b, e;
            run_pixel(10'd431, 10'd257, 1'b1, 1'b0, b, e);
            n_checks++;
            if (b !== 1'b0 || e !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_blank_431: bit=%b en=%b, expected 0/1", b, e);
            end
            run_pixel(10'd415, 10'd270, 1'b1, 1'b0, b, e);
            n_checks++;
            if (b !== 1'b0 || e !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_blank_415: bit=%b en=%b, expected 0/1", b, e);
            end
        end
    endtask

    task automatic test_letter_d;
        logic [9:0] hv [6];
        logic [9:0] vv [6];
        logic       eb [6];
        logic       ee [6];
        logic b, e;
        // 'D' row1 = F8, row2 = 6C; row 0/15 blank; 255/272 outside vertically
        hv = '{10'd400, 10'd405, 10'd400, 10'd400, 10'd400, 10'd402};
        vv = '{10'd257, 10'd257, 10'd256, 10'd255, 10'd272, 10'd258};
        eb = '{1'b1,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1};
        ee = '{1'b1,    1'b1,    1'b1,    1'b0,    1'b0,    1'b1};
        write_slot(2'd0, 2'd1);
        for (int i = 0; i < 6; i++) begin
            run_pixel(hv[i], vv[i], 1'b1, 1'b0, b, e);
            n_checks++;
            if (b !== eb[i] || e !== ee[i]) begin
                n_fail++;
                $display("FAIL letter_d[%0d] Qh=%0d Qv=%0d: bit=%b en=%b, expected %b/%b",
                         i, hv[i], vv[i], b, e, eb[i], ee[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] fila_ref;
        fila_ref = 8'hF8;
        for (int i = 0; i < 10; i++) begin
            @(negedge reloj);
            bus.Qh = 10'(400 + i); bus.Qv = 10'd257; bus.video_on = 1'b1; bus.escala = 1'b0;
            @(posedge reloj); #1;
            if (i >= 2) begin
                n_checks++;
                if (bus.bit_fuente !== fila_ref[9 - i] || bus.en_texto !== 1'b1) begin
                    n_fail++;
                    $display("FAIL back_to_back[%0d]: bit=%b en=%b, expected %b/1",
                             i - 2, bus.bit_fuente, bus.en_texto, fila_ref[9 - i]);
                end
            end
        end
    endtask

    task automatic test_letter_j;
        logic [9:0] hv [5];
        logic       eb [5];
        logic       ee [5];
        logic b, e;
        // 'J' row1 = 1E; 431 is last pixel (slot3 blank); 399/432 just outside
        hv = '{10'd411, 10'd408, 10'd432, 10'd399, 10'd431};
        eb = '{1'b1,    1'b0,    1'b0,    1'b0,    1'b0};
        ee = '{1'b1,    1'b1,    1'b0,    1'b0,    1'b1};
        write_slot(2'd1, 2'd2);
        for (int i = 0; i < 5; i++) begin
            run_pixel(hv[i], 10'd257, 1'b1, 1'b0, b, e);
            n_checks++;
            if (b !== eb[i] || e !== ee[i]) begin
                n_fail++;
                $display("FAIL letter_j[%0d] Qh=%0d: bit=%b en=%b, expected %b/%b",
                         i, hv[i], b, e, eb[i], ee[i]);
            end
        end
    endtask

    task automatic test_scale2x;
        logic [9:0] hv [7];
        logic [9:0] vv [7];
        logic       eb [7];
        logic       ee [7];
        logic b, e;
        // Qv=285 -> row 14 (F8); Qv=287 -> row 15 (blank); 463 last pixel, 464 outside
        hv = '{10'd409, 10'd410, 10'd400, 10'd400, 10'd400, 10'd463, 10'd464};
        vv = '{10'd258, 10'd258, 10'd285, 10'd287, 10'd288, 10'd258, 10'd258};
        eb = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0};
        ee = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b1,    1'b0};
        write_slot(2'd0, 2'd1);
        for (int i = 0; i < 7; i++) begin
            run_pixel(hv[i], vv[i], 1'b1, 1'b1, b, e);
            n_checks++;
            if (b !== eb[i] || e !== ee[i]) begin
                n_fail++;
                $display("FAIL scale2x[%0d] Qh=%0d Qv=%0d: bit=%b en=%b, expected %b/%b",
                         i, hv[i], vv[i], b, e, eb[i], ee[i]);
            end
        end
    endtask

    task automatic test_collision;
        logic b, e;
        @(negedge reloj);
        bus.Qh = 10'd400; bus.Qv = 10'd257; bus.video_on = 1'b1; bus.escala = 1'b0;
        @(posedge reloj);
        @(negedge reloj);
        bus.Qh = 10'd401; bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_code = 2'd2;
        @(posedge reloj);
        @(negedge reloj);
        bus.wr_en = 1'b0; bus.Qh = 10'd440;
        @(posedge reloj); #1;
        n_checks++;
        if (bus.bit_fuente !== 1'b1 || bus.en_texto !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_old: bit=%b en=%b, expected 1/1", bus.bit_fuente, bus.en_texto);
        end
        @(posedge reloj); #1;
        n_checks++;
        if (bus.bit_fuente !== 1'b0 || bus.en_texto !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_new: bit=%b en=%b, expected 0/1", bus.bit_fuente, bus.en_texto);
        end
        run_pixel(10'd400, 10'd257, 1'b1, 1'b0, b, e);
        n_checks++;
        if (b !== 1'b0 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_after: bit=%b en=%b, expected 0/1", b, e);
        end
    endtask

    task automatic test_reset_priority;
        logic b, e;
        @(negedge reloj);
        resetM = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_code = 2'd1;
        @(posedge reloj); #1;
        n_checks++;
        if (bus.bit_fuente !== 1'b0 || bus.en_texto !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_outputs: bit=%b en=%b, expected 0/0", bus.bit_fuente, bus.en_texto);
        end
        @(negedge reloj);
        resetM = 1'b0; bus.wr_en = 1'b0;
        run_pixel(10'd416, 10'd257, 1'b1, 1'b0, b, e);
        n_checks++;
        if (b !== 1'b0 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_slot2: bit=%b en=%b, expected 0/1", b, e);
        end
        run_pixel(10'd403, 10'd257, 1'b1, 1'b0, b, e);
        n_checks++;
        if (b !== 1'b0 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_slot0_blank: bit=%b en=%b, expected 0/1", b, e);
        end
    endtask

    task automatic test_gating;
        logic b, e;
        write_slot(2'd0, 2'd1);
        run_pixel(10'd400, 10'd257, 1'b0, 1'b0, b, e);
        n_checks++;
        if (b !== 1'b0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL gating_off: bit=%b en=%b, expected 0/0", b, e);
        end
        run_pixel(10'd400, 10'd257, 1'b1, 1'b0, b, e);
        n_checks++;
        if (b !== 1'b1 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL gating_on: bit=%b en=%b, expected 1/1", b, e);
        end
    endtask

    initial begin
        bus.Qh = '0; bus.Qv = '0; bus.video_on = 1'b0; bus.escala = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_code = '0;
        test_reset();
        test_letter_d();
        test_back_to_back();
        test_letter_j();
        test_scale2x();
        test_collision();
        test_reset_priority();
        test_gating();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
